// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, saturation limits and the round/saturate helper for the FIR output chain.
package fir_pkg;
    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 8;
    localparam int SAT_MAX   = 2 ** (OUT_W_DEF - 1) - 1;
    localparam int SAT_MIN   = -(2 ** (OUT_W_DEF - 1));

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } rs_t;

    // Round half-up by adding half an LSB before the arithmetic shift, then clip to out_w signed.
    function automatic rs_t round_sat(input logic signed [31:0] x, input int shift, input int out_w);
        logic signed [31:0] t, hi, lo;
        rs_t r;
        t     = (x + ((shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0)) >>> shift;
        hi    = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo    = -hi - 32'sd1;
        r.sat = (t > hi) || (t < lo);
        r.val = (t > hi) ? hi : (t < lo) ? lo : t;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a write into a full FIFO only lands when a pop frees a slot.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    always_comb begin
        level   = wr_q - rd_q;
        full    = level == (AW + 1)'(DEPTH);
        empty   = level == '0;
        rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        wr_d    = wr_q + (AW + 1)'(do_wr);
        rd_d    = rd_q + (AW + 1)'(do_rd);
        mem_d   = mem_q;
        if (do_wr) mem_d[wr_q[AW-1:0]] = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: keeps every DECIM-th filter sample, rounds/saturates it and queues it for a valid/ready sink.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 4,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_valid,
    input  logic signed [IN_W-1:0]   din,
    input  logic                     flag_clr,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic signed [OUT_W-1:0]  dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     overflow
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [PW-1:0]    phase_q, phase_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_data_q, s1_data_d;
    logic             sat_q, sat_d, ovf_q, ovf_d;
    logic             keep, pop, full, empty;
    logic [OUT_W-1:0] head;
    rs_t              rs;

    // Set events take priority over a simultaneous software clear.
    always_comb begin
        keep       = din_valid && (phase_q == '0);
        rs         = round_sat(32'(din), SHIFT, OUT_W);
        phase_d    = !din_valid ? phase_q : (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        s1_valid_d = keep;
        s1_data_d  = keep ? OUT_W'(rs.val) : s1_data_q;
        pop        = dout_valid && dout_ready;
        sat_d      = (keep && rs.sat) || (sat_q && !flag_clr);
        ovf_d      = (s1_valid_q && full && !pop) || (ovf_q && !flag_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(OUT_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s1_valid_q),
        .wr_data (s1_data_q),
        .rd_en   (dout_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign dout       = $signed(head);
    assign dout_valid = !empty;
    assign sat_flag   = sat_q;
    assign overflow   = ovf_q;
endmodule
